rriot_bus_master: RTL and testbench



---
 rtl/rriot_bus_master.sv | 132 +++++++++++++
 tb/tb_rriot_bus_master.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rriot_bus_master.sv
// Bus master for an RRIOT: host commands are queued in a 4-deep FIFO and executed
// one at a time as single-cycle device accesses. Define RRIOT_WRITE_ACK_EN to get responses for writes.
module rriot_bus_master (
    input  logic        phi2,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic        cmd_rs_n,
    input  logic [9:0]  cmd_addr,
    input  logic [7:0]  cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_err,
    output logic [2:0]  fifo_level,
    output logic        we_n,
    output logic [9:0]  A,
    output logic [7:0]  DI,
    output logic        RS_n,
    input  logic [7:0]  DO,
    input  logic        OE
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t      state;
    logic [19:0] fifo_mem [4];
    logic [1:0]  wr_ptr;
    logic [1:0]  rd_ptr;
    logic [2:0]  count;
    logic        push;
    logic        pop;
    logic [19:0] head;
    logic        cur_we;

    assign cmd_ready  = (count < 3'd4);
    assign push       = cmd_valid && cmd_ready;
    assign pop        = (state == IDLE) && (count != 3'd0);
    assign head       = fifo_mem[rd_ptr];
    assign fifo_level = count;

    // Entry layout: {we, rs_n, addr[9:0], wdata[7:0]}; storage needs no reset.
    always_ff @(posedge phi2) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {cmd_we, cmd_rs_n, cmd_addr, cmd_wdata};
        end
    end

    always_ff @(posedge phi2 or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            count  <= 3'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    // Bus outputs are registered so the device sees exactly one cycle per access.
    always_ff @(posedge phi2 or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cur_we    <= 1'b0;
            we_n      <= 1'b1;
            A         <= 10'd0;
            DI        <= 8'd0;
            RS_n      <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 8'd0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        state  <= ACCESS;
                        cur_we <= head[19];
                        we_n   <= !head[19];
                        RS_n   <= head[18];
                        A      <= head[17:8];
                        DI     <= head[19] ? head[7:0] : 8'd0;
                    end
                end
                ACCESS: begin
                    we_n <= 1'b1;
                    A    <= 10'd0;
                    DI   <= 8'd0;
                    RS_n <= 1'b1;
                    if (cur_we) begin
`ifdef RRIOT_WRITE_ACK_EN
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= 8'd0;
                        rsp_err   <= 1'b0;
`else
                        state     <= IDLE;
`endif
                    end else begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= OE ? DO : 8'h00;
                        rsp_err   <= !OE;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rriot_bus_master.sv
// Directed bench for rriot_bus_master: read, write, error read, backpressure,
// simultaneous push/pop and mid-access reset, with hand-computed expectations.
module tb_rriot_bus_master;

    logic        phi2;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic        cmd_rs_n;
    logic [9:0]  cmd_addr;
    logic [7:0]  cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic [2:0]  fifo_level;
    logic        we_n;
    logic [9:0]  A;
    logic [7:0]  DI;
    logic        RS_n;
    logic [7:0]  dev_do;
    logic        OE;

    logic        use_model;
    logic [7:0]  fixed_do;

    int vectors;
    int miscompares;

    // Device model: either a fixed data byte or one derived from the address.
    assign dev_do = use_model ? (A[7:0] + 8'h10) : fixed_do;

    rriot_bus_master dut (
        .phi2       (phi2),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_we     (cmd_we),
        .cmd_rs_n   (cmd_rs_n),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .fifo_level (fifo_level),
        .we_n       (we_n),
        .A          (A),
        .DI         (DI),
        .RS_n       (RS_n),
        .DO         (dev_do),
        .OE         (OE)
    );

    initial begin
        phi2 = 1'b0;
        forever #5 phi2 = ~phi2;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge phi2);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic we, input logic rs_n, input logic [9:0] addr,
                                 input logic [7:0] wdata, output logic accepted);
        cmd_we    = we;
        cmd_rs_n  = rs_n;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_valid = 1'b1;
        accepted  = cmd_ready;
        tick();
        cmd_valid = 1'b0;
    endtask

    logic       acc;
    int         n_acc;
    int         n_rsp;
    logic       any_valid;
    logic [7:0] held_rdata;

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b1;
        cmd_valid   = 1'b0;
        cmd_we      = 1'b0;
        cmd_rs_n    = 1'b1;
        cmd_addr    = 10'd0;
        cmd_wdata   = 8'd0;
        rsp_ready   = 1'b0;
        OE          = 1'b0;
        use_model   = 1'b0;
        fixed_do    = 8'h00;
        #1 rst_n = 1'b0;
        #2;

        // Reset state
        checkOutput("reset_cmd_ready", cmd_ready, 1);
        checkOutput("reset_fifo_level", fifo_level, 0);
        checkOutput("reset_rsp_valid", rsp_valid, 0);
        checkOutput("reset_rsp_rdata", rsp_rdata, 0);
        checkOutput("reset_rsp_err", rsp_err, 0);
        checkOutput("reset_we_n", we_n, 1);
        checkOutput("reset_A", A, 0);
        checkOutput("reset_DI", DI, 0);
        checkOutput("reset_RS_n", RS_n, 1);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Plain read
        OE = 1'b1;
        fixed_do = 8'hA5;
        applyStimulus(1'b0, 1'b1, 10'h3C0, 8'h00, acc);
        checkOutput("rd_accepted", acc, 1);
        checkOutput("rd_level_after_push", fifo_level, 1);
        checkOutput("rd_idle_we_n", we_n, 1);
        tick();
        checkOutput("rd_access_we_n", we_n, 1);
        checkOutput("rd_access_A", A, 10'h3C0);
        checkOutput("rd_access_RS_n", RS_n, 1);
        checkOutput("rd_access_DI", DI, 0);
        checkOutput("rd_access_rsp_valid", rsp_valid, 0);
        checkOutput("rd_access_level", fifo_level, 0);
        tick();
        checkOutput("rd_rsp_valid", rsp_valid, 1);
        checkOutput("rd_rsp_rdata", rsp_rdata, 8'hA5);
        checkOutput("rd_rsp_err", rsp_err, 0);
        checkOutput("rd_bus_idle_A", A, 0);
        fixed_do = 8'h3C;
        tick();
        checkOutput("rd_hold_valid", rsp_valid, 1);
        checkOutput("rd_hold_rdata", rsp_rdata, 8'hA5);
        rsp_ready = 1'b1;
        tick();
        checkOutput("rd_taken", rsp_valid, 0);
        rsp_ready = 1'b0;

        // Write
        applyStimulus(1'b1, 1'b1, 10'h041, 8'h5A, acc);
        checkOutput("wr_accepted", acc, 1);
        tick();
        checkOutput("wr_access_we_n", we_n, 0);
        checkOutput("wr_access_A", A, 10'h041);
        checkOutput("wr_access_DI", DI, 8'h5A);
        tick();
        checkOutput("wr_strobe_one_cycle", we_n, 1);
        checkOutput("wr_DI_cleared", DI, 0);
`ifdef RRIOT_WRITE_ACK_EN
        checkOutput("wr_ack_valid", rsp_valid, 1);
        checkOutput("wr_ack_rdata", rsp_rdata, 0);
        checkOutput("wr_ack_err", rsp_err, 0);
        rsp_ready = 1'b1;
        tick();
        checkOutput("wr_ack_taken", rsp_valid, 0);
        rsp_ready = 1'b0;
`else
        any_valid = rsp_valid;
        for (int i = 0; i < 5; i++) begin
            tick();
            any_valid = any_valid | rsp_valid;
        end
        checkOutput("wr_no_response", any_valid, 0);
`endif

        // Error read
        OE = 1'b0;
        fixed_do = 8'hFF;
        applyStimulus(1'b0, 1'b0, 10'h155, 8'h00, acc);
        tick();
        checkOutput("err_access_RS_n", RS_n, 0);
        checkOutput("err_access_A", A, 10'h155);
        tick();
        checkOutput("err_rsp_valid", rsp_valid, 1);
        checkOutput("err_rsp_rdata", rsp_rdata, 8'h00);
        checkOutput("err_rsp_err", rsp_err, 1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Backpressure: six reads offered while responses are held off
        OE = 1'b1;
        use_model = 1'b1;
        n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 1'b1, 10'(i), 8'h00, acc);
            if (acc) n_acc++;
        end
        checkOutput("full_accepted", n_acc, 5);
        checkOutput("full_level", fifo_level, 4);
        checkOutput("full_cmd_ready", cmd_ready, 0);
        checkOutput("full_rsp_valid", rsp_valid, 1);
        checkOutput("full_first_rdata", rsp_rdata, 8'h10);
        held_rdata = rsp_rdata;
        tick();
        checkOutput("full_hold_rdata", rsp_rdata, 8'h10);
        checkOutput("full_hold_level", fifo_level, 4);
        rsp_ready = 1'b1;
        n_rsp = 0;
        for (int t = 0; t < 30; t++) begin
            if (rsp_valid) begin
                if (n_rsp < 5) begin
                    checkOutput("full_order_rdata", rsp_rdata, 32'(n_rsp) + 32'h10);
                end
                n_rsp++;
            end
            tick();
        end
        checkOutput("full_rsp_count", n_rsp, 5);
        checkOutput("full_drained_level", fifo_level, 0);
        rsp_ready = 1'b0;

        // Simultaneous push and pop at level 2
        applyStimulus(1'b0, 1'b1, 10'h020, 8'h00, acc);
        applyStimulus(1'b0, 1'b1, 10'h021, 8'h00, acc);
        applyStimulus(1'b0, 1'b1, 10'h022, 8'h00, acc);
        checkOutput("pp_level_before", fifo_level, 2);
        checkOutput("pp_in_resp", rsp_valid, 1);
        checkOutput("pp_resp_rdata", rsp_rdata, 8'h30);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checkOutput("pp_level_idle", fifo_level, 2);
        applyStimulus(1'b0, 1'b1, 10'h023, 8'h00, acc);
        checkOutput("pp_accepted", acc, 1);
        checkOutput("pp_level_same", fifo_level, 2);
        checkOutput("pp_access_A", A, 10'h021);
        rsp_ready = 1'b1;
        for (int t = 0; t < 20; t++) tick();
        checkOutput("pp_drained_level", fifo_level, 0);
        rsp_ready = 1'b0;

        // Reset in the middle of a write access with a command still queued
        applyStimulus(1'b1, 1'b1, 10'h2AA, 8'h33, acc);
        applyStimulus(1'b0, 1'b1, 10'h011, 8'h00, acc);
        checkOutput("rst_access_we_n", we_n, 0);
        checkOutput("rst_level_before", fifo_level, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_we_n_async", we_n, 1);
        checkOutput("rst_A_async", A, 0);
        checkOutput("rst_DI_async", DI, 0);
        checkOutput("rst_level_async", fifo_level, 0);
        checkOutput("rst_cmd_ready_async", cmd_ready, 1);
        tick();
        rst_n = 1'b1;
        rsp_ready = 1'b0;
        any_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            any_valid = any_valid | rsp_valid | !we_n;
        end
        checkOutput("rst_no_response", any_valid, 0);
        checkOutput("rst_level_after", fifo_level, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
